// File: rtl/demo_pkg.sv
// Shared types and constants for the demo song recorder.
package demo_pkg;

    localparam int DEMO_NUM     = 25;
    localparam int DEMO_C       = 12;
    localparam int DEMO_WORD_W  = 96;
    localparam int DEMO_VOICES  = 6;
    localparam int DEMO_VOICE_W = 16;

    localparam int VOICE_PITCH_MSB = 15;
    localparam int VOICE_PITCH_LSB = 4;
    localparam int VOICE_LVL_MSB   = 3;
    localparam int VOICE_LVL_LSB   = 2;
    localparam int VOICE_WAVE_MSB  = 1;
    localparam int VOICE_WAVE_LSB  = 0;

    typedef enum logic [1:0] {
        LVL_OFF = 2'd0,
        LVL_1   = 2'd1,
        LVL_2   = 2'd2,
        LVL_4   = 2'd3
    } level_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECORD,
        ST_PAD,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/demo_voice_packer.sv
// Packs one 4-channel group into a 16-bit song voice word.
module demo_voice_packer
    import demo_pkg::*;
(
    input  logic [3:0]              ena,
    input  logic [DEMO_C-1:0]       pitch,
    input  logic [1:0]              wave,
    output logic [DEMO_VOICE_W-1:0] voice
);

    level_e level;

    always_comb begin
        level = LVL_OFF;
        voice = '0;
        if (ena == 4'b1111) begin
            level = LVL_4;
        end else if (ena[1:0] == 2'b11) begin
            level = LVL_2;
        end else if (ena[0]) begin
            level = LVL_1;
        end
        if (level != LVL_OFF) begin
            voice[VOICE_PITCH_MSB:VOICE_PITCH_LSB] = pitch;
            voice[VOICE_LVL_MSB:VOICE_LVL_LSB]     = level;
            voice[VOICE_WAVE_MSB:VOICE_WAVE_LSB]   = wave;
        end
    end

endmodule

// File: rtl/demo_encoder.sv
// Records live channel state into demo RAM as 96-bit song words.
// Define DEMO_ENCODER_PAD_EN to zero-fill the remaining words after stop.
module demo_encoder
    import demo_pkg::*;
#(
    parameter int DEMO_SONG_LENGTH = 128,
    parameter int DEMO_CLK_DIVIDE  = 100
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                stop,
    input  logic [DEMO_NUM*DEMO_C-1:0]          pitches,
    input  logic [DEMO_NUM-1:0]                 channel_ena,
    input  logic [DEMO_NUM*2-1:0]               waveforms,
    output logic [$clog2(DEMO_SONG_LENGTH)-1:0] rec_addr,
    output logic [DEMO_WORD_W-1:0]              rec_data,
    output logic                                rec_we,
    output logic                                busy,
    output logic                                done
);

    localparam int AW = $clog2(DEMO_SONG_LENGTH);
    localparam int WW = AW + 1;
    localparam int TW = $clog2(DEMO_CLK_DIVIDE);

    logic [DEMO_WORD_W-1:0] sample;

    for (genvar v = 0; v < DEMO_VOICES; v++) begin : g_voice
        localparam int B = 20 - 4 * v;
        demo_voice_packer u_packer (
            .ena   (channel_ena[B+3:B]),
            .pitch (pitches[DEMO_C*B +: DEMO_C]),
            .wave  (waveforms[2*B +: 2]),
            .voice (sample[DEMO_VOICE_W*v +: DEMO_VOICE_W])
        );
    end

    // Channel 24 has no slot in the song word.
    logic unused_ch24;
    assign unused_ch24 = ^{channel_ena[24], pitches[299:288], waveforms[49:48]};

    state_e                 state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [WW-1:0]          widx_q, widx_d;
    logic [AW-1:0]          rec_addr_q, rec_addr_d;
    logic [DEMO_WORD_W-1:0] rec_data_q, rec_data_d;
    logic                   rec_we_q, rec_we_d;

    logic last_wr;
    logic sample_now;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        widx_d     = widx_q;
        rec_addr_d = rec_addr_q;
        rec_data_d = rec_data_q;
        rec_we_d   = 1'b0;
        last_wr    = rec_we_q && (rec_addr_q == AW'(DEMO_SONG_LENGTH - 1));
        sample_now = (tick_q == '0) && (widx_q < WW'(DEMO_SONG_LENGTH));
        unique case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                widx_d = '0;
                if (start && !stop) begin
                    state_d = ST_RECORD;
                end
            end
            ST_RECORD: begin
                if (tick_q == TW'(DEMO_CLK_DIVIDE - 1)) begin
                    tick_d = '0;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
                // Completing the final write outranks a late stop.
                if (last_wr) begin
                    state_d = ST_FINISH;
                end else if (stop) begin
`ifdef DEMO_ENCODER_PAD_EN
                    state_d    = ST_PAD;
                    rec_we_d   = 1'b1;
                    rec_addr_d = widx_q[AW-1:0];
                    rec_data_d = '0;
                    widx_d     = widx_q + WW'(1);
`else
                    state_d = ST_IDLE;
`endif
                end else if (sample_now) begin
                    rec_we_d   = 1'b1;
                    rec_addr_d = widx_q[AW-1:0];
                    rec_data_d = sample;
                    widx_d     = widx_q + WW'(1);
                end
            end
            ST_PAD: begin
                if (last_wr) begin
                    state_d = ST_FINISH;
                end else begin
                    rec_we_d   = 1'b1;
                    rec_addr_d = widx_q[AW-1:0];
                    rec_data_d = '0;
                    widx_d     = widx_q + WW'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tick_q     <= '0;
            widx_q     <= '0;
            rec_addr_q <= '0;
            rec_data_q <= '0;
            rec_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            widx_q     <= widx_d;
            rec_addr_q <= rec_addr_d;
            rec_data_q <= rec_data_d;
            rec_we_q   <= rec_we_d;
        end
    end

    assign rec_addr = rec_addr_q;
    assign rec_data = rec_data_q;
    assign rec_we   = rec_we_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FINISH);

endmodule

// File: tb/tb_demo_encoder.sv
// Self-checking bench for demo_encoder (DEMO_CLK_DIVIDE=4, DEMO_SONG_LENGTH=8).
module tb_demo_encoder;

    localparam int LEN = 8;
    localparam int DIV = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [299:0] pitches = '0;
    logic [24:0]  channel_ena = '0;
    logic [49:0]  waveforms = '0;
    logic [2:0]   rec_addr;
    logic [95:0]  rec_data;
    logic         rec_we;
    logic         busy;
    logic         done;

    demo_encoder #(
        .DEMO_SONG_LENGTH (LEN),
        .DEMO_CLK_DIVIDE  (DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .pitches     (pitches),
        .channel_ena (channel_ena),
        .waveforms   (waveforms),
        .rec_addr    (rec_addr),
        .rec_data    (rec_data),
        .rec_we      (rec_we),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [95:0] data;
        int          at;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic [24:0]  en;
        logic [299:0] p;
        logic [49:0]  w;
        logic [95:0]  exp;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [95:0] model(input logic [24:0] en,
                                          input logic [299:0] p,
                                          input logic [49:0] w);
        logic [95:0] r;
        logic [3:0]  e;
        logic [1:0]  l;
        int          b;
        r = '0;
        for (int v = 0; v < 6; v++) begin
            b = 20 - 4 * v;
            e = en[b +: 4];
            if (e == 4'hF) l = 2'd3;
            else if (e[1:0] == 2'b11) l = 2'd2;
            else if (e[0]) l = 2'd1;
            else l = 2'd0;
            if (l == 2'd0) r[16*v +: 16] = 16'h0;
            else r[16*v +: 16] = {p[12*b +: 12], l, w[2*b +: 2]};
        end
        return r;
    endfunction

    // Scoreboard side: every write is popped and compared here.
    always @(negedge clk) begin
        wr_t e;
        if (done) done_cnt++;
        if (rec_we) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%h cyc=%0d",
                         rec_addr, rec_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 96'(rec_addr), 96'(e.addr));
                chk("wr_data", rec_data, e.data);
                chk("wr_cycle", 96'(cyc), 96'(e.at));
            end
        end
    end

    task automatic apply(input vec_t v);
        channel_ena = v.en;
        pitches     = v.p;
        waveforms   = v.w;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int a, input logic [95:0] d, input int at);
        wr_t e;
        e.addr = 3'(a);
        e.data = d;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic pulse_start(output int s);
        @(posedge clk);
        #1;
        start = 1'b1;
        s = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 64);
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required_cyc=%0d", exp_cyc);
        end else begin
            chk("done_cycle", 96'(cyc), 96'(exp_cyc));
        end
        @(negedge clk);
        chk("busy_after_done", 96'(busy), 96'(0));
        chk("done_one_cycle", 96'(done), 96'(0));
    endtask

    task automatic sb_drain(input string name);
        chk(name, 96'(sb.size()), 96'(0));
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int s;
        int dc;
        logic [95:0] m;

        for (int i = 0; i < 8; i++) begin
            tbl[i].en = '0;
            tbl[i].p  = '0;
            tbl[i].w  = '0;
        end
        tbl[0].en = 25'h0300000;
        tbl[0].p[240 +: 12] = 12'h1A3;
        tbl[0].w[40 +: 2] = 2'd2;
        tbl[0].exp = {80'h0, 16'h1A3A};
        tbl[1].en = 25'h000000F;
        tbl[1].p[0 +: 12] = 12'h456;
        tbl[1].w[0 +: 2] = 2'd1;
        tbl[1].exp = {16'h456D, 80'h0};
        tbl[2].en = 25'h0000003;
        tbl[2].p[0 +: 12] = 12'h456;
        tbl[2].w[0 +: 2] = 2'd3;
        tbl[2].exp = {16'h456B, 80'h0};
        tbl[3].en = 25'h0000001;
        tbl[3].p[0 +: 12] = 12'h456;
        tbl[3].exp = {16'h4564, 80'h0};
        tbl[4].en = 25'h1000004;
        tbl[4].p[0 +: 12] = 12'h456;
        tbl[4].p[288 +: 12] = 12'hFFF;
        tbl[4].w[0 +: 2] = 2'd2;
        tbl[4].w[48 +: 2] = 2'd3;
        tbl[4].exp = 96'h0;
        for (int i = 5; i < 8; i++) begin
            tbl[i].en = 25'($urandom);
            for (int k = 0; k < 25; k++) begin
                tbl[i].p[12*k +: 12] = 12'($urandom);
                tbl[i].w[2*k +: 2] = 2'($urandom);
            end
            tbl[i].exp = model(tbl[i].en, tbl[i].p, tbl[i].w);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", 96'(rec_addr), 96'(0));
        chk("rst_data", rec_data, 96'h0);
        chk("rst_we", 96'(rec_we), 96'(0));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_done", 96'(done), 96'(0));
        rst_n = 1'b1;

        // Full run, one table vector per song word; a stray start mid-run.
        apply(tbl[0]);
        @(posedge clk);
        #1;
        start = 1'b1;
        s = cyc;
        for (int i = 0; i < LEN; i++) push(i, tbl[i].exp, s + 2 + DIV * i);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_record", 96'(busy), 96'(1));
        for (int i = 1; i < LEN; i++) begin
            if (i == 3) begin
                go_to(s + 10);
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            go_to(s + DIV * i - 1);
            apply(tbl[i]);
        end
        wait_done(s + 31);
        sb_drain("full_run_writes");

        // Stop one cycle after the address-2 write.
        dc = done_cnt;
        apply(tbl[5]);
        m = model(tbl[5].en, tbl[5].p, tbl[5].w);
        pulse_start(s);
        for (int i = 0; i < 3; i++) push(i, m, s + 2 + DIV * i);
`ifdef DEMO_ENCODER_PAD_EN
        for (int i = 3; i < LEN; i++) push(i, 96'h0, s + 12 + (i - 3));
`endif
        go_to(s + 11);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
`ifdef DEMO_ENCODER_PAD_EN
        wait_done(s + 17);
        chk("stop_done_cnt", 96'(done_cnt), 96'(dc + 1));
`else
        chk("stop_busy_low", 96'(busy), 96'(0));
        go_to(s + 40);
        chk("stop_no_done", 96'(done_cnt), 96'(dc));
`endif
        sb_drain("stop_writes");

        // start and stop together in IDLE.
        dc = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_busy", 96'(busy), 96'(0));
        go_to(cyc + 12);
        chk("startstop_idle", 96'(busy), 96'(0));
        chk("startstop_no_done", 96'(done_cnt), 96'(dc));

        // stop in the same cycle as the second sample.
        dc = done_cnt;
        apply(tbl[6]);
        m = model(tbl[6].en, tbl[6].p, tbl[6].w);
        pulse_start(s);
        push(0, m, s + 2);
`ifdef DEMO_ENCODER_PAD_EN
        for (int i = 1; i < LEN; i++) push(i, 96'h0, s + 5 + i);
`endif
        go_to(s + 5);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
`ifdef DEMO_ENCODER_PAD_EN
        wait_done(s + 13);
`else
        chk("coinc_busy_low", 96'(busy), 96'(0));
        go_to(s + 20);
        chk("coinc_no_done", 96'(done_cnt), 96'(dc));
`endif
        sb_drain("coinc_writes");

        // Asynchronous reset while a write is on the port.
        apply(tbl[7]);
        m = model(tbl[7].en, tbl[7].p, tbl[7].w);
        pulse_start(s);
        push(0, m, s + 2);
        go_to(s + 2);
        #5;
        chk("we_before_rst", 96'(rec_we), 96'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_we", 96'(rec_we), 96'(0));
        chk("arst_busy", 96'(busy), 96'(0));
        chk("arst_addr", 96'(rec_addr), 96'(0));
        #1;
        rst_n = 1'b1;
        sb_drain("arst_writes");
        pulse_start(s);
        for (int i = 0; i < LEN; i++) push(i, m, s + 2 + DIV * i);
        wait_done(s + 31);
        sb_drain("rerun_writes");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
